// File: rtl/memory_pkg.sv
// Shared memory response codes and the request legality check used by the RAM
// and by writeback_cache.
package memory_pkg;

  typedef enum logic [2:0] {
    MEMORY_ACCESS_OK,
    MEMORY_WAIT_READY,
    MEMORY_ERROR_OUT_OF_BOUNDS,
    MEMORY_ERROR_MISALIGNED,
    MEMORY_ERROR_READONLY,
    MEMORY_ERROR_WRITEONLY
  } memory_status_t;

  // Bounds beat alignment: an out-of-range address reports OUT_OF_BOUNDS even if misaligned.
  function automatic memory_status_t check_access(input logic [63:0] addr,
                                                  input logic [63:0] size_bytes,
                                                  input logic [63:0] align_bytes);
    check_access = MEMORY_ACCESS_OK;
    if (addr > size_bytes - 64'd1)
      check_access = MEMORY_ERROR_OUT_OF_BOUNDS;
    else if ((addr & (align_bytes - 64'd1)) != 64'd0)
      check_access = MEMORY_ERROR_MISALIGNED;
  endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// One RAM port: request register, error decode, access-stage controls toward
// the shared array, and the response pipeline for the configured latency.
module ram_port_pipe
  import memory_pkg::*;
#(
  parameter  int word_size  = 4,
  parameter  int word_count = 256,
  parameter  int latency    = 2,
  parameter  int addr_width = $clog2(word_count * word_size) + 1,
  localparam int DATA_W     = 8 * word_size,
  localparam int OFFSET_W   = $clog2(word_size),
  localparam int IDX_W      = addr_width - 1 - OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [addr_width-1:0] i_address,
  input  logic [word_size-1:0]  i_wmask,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W-1:0]     i_rd_word,
  output logic                  o_acc_write,
  output logic [IDX_W-1:0]      o_acc_idx,
  output logic [word_size-1:0]  o_acc_wmask,
  output logic [DATA_W-1:0]     o_acc_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_W-1:0]     o_rdata,
  output memory_status_t        o_status
);

  logic                  w_a_valid;
  logic                  w_a_we;
  logic [addr_width-1:0] w_a_addr;
  logic [word_size-1:0]  w_a_wmask;
  logic [DATA_W-1:0]     w_a_wdata;

  if (latency == 1) begin : g_direct
    assign w_a_valid = i_req;
    assign w_a_we    = i_we;
    assign w_a_addr  = i_address;
    assign w_a_wmask = i_wmask;
    assign w_a_wdata = i_wdata;
  end else begin : g_in_reg
    logic                  r_valid;
    logic                  r_we;
    logic [addr_width-1:0] r_addr;
    logic [word_size-1:0]  r_wmask;
    logic [DATA_W-1:0]     r_wdata;

    // NOTE: sequential state uses <= so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= '0;
        r_wmask <= '0;
        r_wdata <= '0;
      end else begin
        r_valid <= i_req;
        if (i_req) begin
          r_we    <= i_we;
          r_addr  <= i_address;
          r_wmask <= i_wmask;
          r_wdata <= i_wdata;
        end
      end
    end

    assign w_a_valid = r_valid;
    assign w_a_we    = r_we;
    assign w_a_addr  = r_addr;
    assign w_a_wmask = r_wmask;
    assign w_a_wdata = r_wdata;
  end

  memory_status_t    w_a_status;
  logic              w_a_ok;
  logic [DATA_W-1:0] w_a_rdata;

  assign w_a_status  = check_access(64'(w_a_addr), 64'(word_count * word_size), 64'(word_size));
  assign w_a_ok      = (w_a_status == MEMORY_ACCESS_OK);
  assign w_a_rdata   = (w_a_ok && !w_a_we) ? i_rd_word : '0;
  assign o_acc_write = w_a_valid && w_a_ok && w_a_we;
  assign o_acc_idx   = w_a_addr[addr_width-2:OFFSET_W];
  assign o_acc_wmask = w_a_wmask;
  assign o_acc_wdata = w_a_wdata;

  logic              w_o_valid;
  logic [DATA_W-1:0] w_o_rdata;
  memory_status_t    w_o_status;

  if (latency == 3) begin : g_mid_reg
    logic              r_mid_valid;
    logic [DATA_W-1:0] r_mid_rdata;
    memory_status_t    r_mid_status;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mid_valid  <= 1'b0;
        r_mid_rdata  <= '0;
        r_mid_status <= MEMORY_ACCESS_OK;
      end else begin
        r_mid_valid <= w_a_valid;
        if (w_a_valid) begin
          r_mid_rdata  <= w_a_rdata;
          r_mid_status <= w_a_status;
        end
      end
    end

    assign w_o_valid  = r_mid_valid;
    assign w_o_rdata  = r_mid_rdata;
    assign w_o_status = r_mid_status;
  end else begin : g_no_mid_reg
    assign w_o_valid  = w_a_valid;
    assign w_o_rdata  = w_a_rdata;
    assign w_o_status = w_a_status;
  end

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  memory_status_t    r_status;

  // rdata/status only load on a valid beat so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_status    <= MEMORY_ACCESS_OK;
    end else begin
      r_rsp_valid <= w_o_valid;
      if (w_o_valid) begin
        r_rdata  <= w_o_rdata;
        r_status <= w_o_status;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rdata     = r_rdata;
  assign o_status    = r_status;

endmodule

// File: rtl/multi_port_ram.sv
// N-port byte-maskable synchronous RAM: per-port pipelines around one shared
// array with read-first access and lowest-port-wins byte merging.
module multi_port_ram
  import memory_pkg::*;
#(
  parameter  int port_count = 2,
  parameter  int word_size  = 4,
  parameter  int word_count = 256,
  parameter  int latency    = 2,
  parameter  int addr_width = $clog2(word_count * word_size) + 1,
  localparam int DATA_W     = 8 * word_size,
  localparam int IDX_W      = addr_width - 1 - $clog2(word_size)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic           [port_count-1:0]        req,
  input  logic           [port_count-1:0]        we,
  input  logic           [port_count-1:0][addr_width-1:0] address,
  input  logic           [port_count-1:0][word_size-1:0]  wmask,
  input  logic           [port_count-1:0][DATA_W-1:0]     wdata,
  output logic           [port_count-1:0]        rsp_valid,
  output logic           [port_count-1:0][DATA_W-1:0]     rdata,
  output memory_status_t [port_count-1:0]        status
);

  if (latency < 1 || latency > 3) begin : g_bad_latency
    $error("multi_port_ram: latency must be 1, 2 or 3");
  end
  if (port_count < 1 || port_count > 4) begin : g_bad_ports
    $error("multi_port_ram: port_count must be 1..4");
  end

  logic [DATA_W-1:0]    r_mem [word_count];

  logic                 w_acc_write [port_count];
  logic [IDX_W-1:0]     w_acc_idx   [port_count];
  logic [word_size-1:0] w_acc_wmask [port_count];
  logic [DATA_W-1:0]    w_acc_wdata [port_count];
  logic [DATA_W-1:0]    w_rd_word   [port_count];

  for (genvar p = 0; p < port_count; p++) begin : g_port
    // Combinational read ahead of the write edge makes same-edge reads return old data.
    assign w_rd_word[p] = r_mem[w_acc_idx[p]];

    ram_port_pipe #(
      .word_size (word_size),
      .word_count(word_count),
      .latency   (latency),
      .addr_width(addr_width)
    ) u_pipe (
      .clk        (clk),
      .rst_n      (reset),
      .i_req      (req[p]),
      .i_we       (we[p]),
      .i_address  (address[p]),
      .i_wmask    (wmask[p]),
      .i_wdata    (wdata[p]),
      .i_rd_word  (w_rd_word[p]),
      .o_acc_write(w_acc_write[p]),
      .o_acc_idx  (w_acc_idx[p]),
      .o_acc_wmask(w_acc_wmask[p]),
      .o_acc_wdata(w_acc_wdata[p]),
      .o_rsp_valid(rsp_valid[p]),
      .o_rdata    (rdata[p]),
      .o_status   (status[p])
    );
  end

  // NOTE: the array has no reset; contents survive reset and it maps onto RAM macros.
  // Ports are visited highest first so port 0's non-blocking write lands last and wins.
  always_ff @(posedge clk) begin
    for (int p = port_count - 1; p >= 0; p--) begin
      for (int b = 0; b < word_size; b++) begin
        if (w_acc_write[p] && w_acc_wmask[p][b])
          r_mem[w_acc_idx[p]][8*b +: 8] <= w_acc_wdata[p][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_ram.sv
// Directed bench: three RAM instances (latency 1, 2, 3) share one stimulus bus
// and are checked against hand-computed responses at their own latencies.
module tb_multi_port_ram;
  import memory_pkg::*;

  localparam int P  = 2;
  localparam int WS = 4;
  localparam int WC = 256;
  localparam int AW = $clog2(WC * WS) + 1;
  localparam int DW = 8 * WS;

  localparam memory_status_t OK  = MEMORY_ACCESS_OK;
  localparam memory_status_t OOB = MEMORY_ERROR_OUT_OF_BOUNDS;
  localparam memory_status_t MIS = MEMORY_ERROR_MISALIGNED;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [P-1:0]                 req, we;
  logic [P-1:0][AW-1:0]         address;
  logic [P-1:0][WS-1:0]         wmask;
  logic [P-1:0][DW-1:0]         wdata;
  logic [P-1:0]                 v1, v2, v3;
  logic [P-1:0][DW-1:0]         d1, d2, d3;
  memory_status_t [P-1:0]       s1, s2, s3;

  int n_vec = 0;
  int n_err = 0;

  multi_port_ram #(.port_count(P), .word_size(WS), .word_count(WC), .latency(1), .addr_width(AW)) u_lat1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wmask(wmask), .wdata(wdata),
    .rsp_valid(v1), .rdata(d1), .status(s1));
  multi_port_ram #(.port_count(P), .word_size(WS), .word_count(WC), .latency(2), .addr_width(AW)) u_lat2 (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wmask(wmask), .wdata(wdata),
    .rsp_valid(v2), .rdata(d2), .status(s2));
  multi_port_ram #(.port_count(P), .word_size(WS), .word_count(WC), .latency(3), .addr_width(AW)) u_lat3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wmask(wmask), .wdata(wdata),
    .rsp_valid(v3), .rdata(d3), .status(s3));

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs {rsp_valid, status, rdata} of one instance/port.
  function automatic logic [35:0] resp(input int inst, input int p);
    case (inst)
      1:       return {v1[p], s1[p], d1[p]};
      2:       return {v2[p], s2[p], d2[p]};
      default: return {v3[p], s3[p], d3[p]};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [WS-1:0] m, input logic [DW-1:0] d);
    req[p]     = 1'b1;
    we[p]      = w;
    address[p] = a;
    wmask[p]   = m;
    wdata[p]   = d;
  endtask

  task automatic write_op(input int p, input logic [AW-1:0] a, input logic [WS-1:0] m,
                          input logic [DW-1:0] d, input memory_status_t es, input string tag);
    drive(p, 1'b1, a, m, d);
    step();
    idle();
    check({tag, "_l1"}, resp(1, p), {1'b1, es, 32'h0});
  endtask

  task automatic read3(input int p, input logic [AW-1:0] a, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                       input memory_status_t es, input string tag);
    drive(p, 1'b0, a, '0, '0);
    step();
    idle();
    check({tag, "_l1"}, resp(1, p), {1'b1, es, e1});
    step();
    check({tag, "_l2"}, resp(2, p), {1'b1, es, e2});
    step();
    check({tag, "_l3"}, resp(3, p), {1'b1, es, e3});
  endtask

  task automatic read_all(input int p, input logic [AW-1:0] a, input logic [DW-1:0] e,
                          input memory_status_t es, input string tag);
    read3(p, a, e, e, e, es, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    req     = '0;
    we      = '0;
    address = '0;
    wmask   = '0;
    wdata   = '0;
    repeat (3) step();
    reset = 1'b1;

    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 1; i <= 3; i++)
        for (int p = 0; p < P; p++)
          check($sformatf("idle_c%0d_l%0d_p%0d", c, i, p), resp(i, p), 36'h0);
    end

    // Write then read on the next cycle; each latency answers on its own edge.
    drive(0, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF);
    step(); idle();
    check("basic_wr_l1", resp(1, 0), {1'b1, OK, 32'h0});
    drive(0, 1'b0, 11'h010, 4'h0, 32'h0);
    step(); idle();
    check("basic_rd_l1", resp(1, 0), {1'b1, OK, 32'hDEADBEEF});
    check("basic_wr_l2", resp(2, 0), {1'b1, OK, 32'h0});
    step();
    check("basic_hold_l1", resp(1, 0), {1'b0, OK, 32'hDEADBEEF});
    check("basic_rd_l2", resp(2, 0), {1'b1, OK, 32'hDEADBEEF});
    check("basic_wr_l3", resp(3, 0), {1'b1, OK, 32'h0});
    step();
    check("basic_hold_l2", resp(2, 0), {1'b0, OK, 32'hDEADBEEF});
    check("basic_rd_l3", resp(3, 0), {1'b1, OK, 32'hDEADBEEF});
    step();
    check("basic_hold_l3", resp(3, 0), {1'b0, OK, 32'hDEADBEEF});

    write_op(0, 11'h010, 4'h0, 32'hFFFFFFFF, OK, "wmask0_wr");
    read_all(0, 11'h010, 32'hDEADBEEF, OK, "wmask0_rd");

    // Byte-masked collision: port 0 wins byte 1, others merge.
    write_op(0, 11'h020, 4'hF, 32'h11223344, OK, "coll_init");
    drive(0, 1'b1, 11'h020, 4'b0011, 32'hAAAAAAAA);
    drive(1, 1'b1, 11'h020, 4'b0110, 32'hBBBBBBBB);
    step(); idle();
    check("coll_wr_p0_l1", resp(1, 0), {1'b1, OK, 32'h0});
    check("coll_wr_p1_l1", resp(1, 1), {1'b1, OK, 32'h0});
    read_all(1, 11'h020, 32'h11BBAAAA, OK, "coll_rd");

    // Read-first on a same-edge read/write, new data one cycle later.
    write_op(0, 11'h040, 4'hF, 32'h0, OK, "rf_init");
    drive(0, 1'b0, 11'h040, 4'h0, 32'h0);
    drive(1, 1'b1, 11'h040, 4'hF, 32'h12345678);
    step(); idle();
    check("rf_old_l1", resp(1, 0), {1'b1, OK, 32'h0});
    drive(0, 1'b0, 11'h040, 4'h0, 32'h0);
    step(); idle();
    check("rf_new_l1", resp(1, 0), {1'b1, OK, 32'h12345678});
    check("rf_old_l2", resp(2, 0), {1'b1, OK, 32'h0});
    step();
    check("rf_new_l2", resp(2, 0), {1'b1, OK, 32'h12345678});
    check("rf_old_l3", resp(3, 0), {1'b1, OK, 32'h0});
    step();
    check("rf_new_l3", resp(3, 0), {1'b1, OK, 32'h12345678});

    // Error decode and address boundaries.
    read_all(0, 11'h402, 32'h0, OOB, "oob_402");
    read_all(1, 11'h400, 32'h0, OOB, "oob_400");
    write_op(1, 11'h3FC, 4'hF, 32'hA5A55A5A, OK, "last_wr");
    read_all(0, 11'h3FC, 32'hA5A55A5A, OK, "last_rd");
    write_op(0, 11'h004, 4'hF, 32'hCAFEF00D, OK, "mis_init");
    write_op(0, 11'h006, 4'hF, 32'hFFFFFFFF, MIS, "mis_wr");
    read_all(0, 11'h004, 32'hCAFEF00D, OK, "mis_rd");
    read_all(1, 11'h005, 32'h0, MIS, "mis_rd_err");

    // Reset mid-flight: reads on cycles 0-2, write on cycle 2, reset on cycle 3.
    write_op(0, 11'h080, 4'hF, 32'h55555555, OK, "rst_init");
    step(); step();
    drive(0, 1'b0, 11'h080, 4'h0, 32'h0);
    step();
    step();
    drive(1, 1'b1, 11'h080, 4'hF, 32'h99999999);
    step(); idle();
    reset = 1'b0;
    #1;
    for (int i = 1; i <= 3; i++)
      for (int p = 0; p < P; p++)
        check($sformatf("rst_clear_l%0d_p%0d", i, p), resp(i, p), 36'h0);
    step(); step();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rst_no_rsp_c%0d", c), 36'({v1, v2, v3}), 36'h0);
    end
    // Latency 1 commits on its request edge; deeper pipelines drop the write.
    read3(0, 11'h080, 32'h99999999, 32'h55555555, 32'h55555555, OK, "rst_nocommit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_port_ram.md
Name: multi_port_ram

Overview:
- Parametrised N-port, byte-addressed, byte-maskable synchronous RAM with selectable pipeline latency.
- Each port has a per-request valid strobe and a response valid strobe, plus a memory_status_t status per response.
- Checks each request for alignment and address bounds; errored requests never touch the array.
- Used as local scratchpad / tag-data storage under the writeback cache and as a core-side tightly coupled memory.

Parameters:
- port_count, 2, number of independent request ports (1..4).
- word_size, 4, bytes per word (power of 2, at least 1).
- word_count, 256, words in the array (power of 2).
- latency, 2, cycles from request edge to response (1, 2 or 3; any other value gives an elaboration $error).
- addr_width, $clog2(word_count*word_size)+1, byte address width; the extra MSB makes out-of-range addresses expressible.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  [port_count]  request valid per port.
- we  in  [port_count]  1 = write, 0 = read.
- address  in  [port_count][addr_width]  byte address.
- wmask  in  [port_count][word_size]  byte write enables; bit i selects wdata byte i.
- wdata  in  [port_count][8*word_size]  write data.
- rsp_valid  out  [port_count]  response valid, one cycle per accepted request.
- rdata  out  [port_count][8*word_size]  read data; 0 for writes and errors.
- status  out  [port_count] x memory_status_t  response status.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release):
  - all pipeline valid bits are cleared; rsp_valid = 0, rdata = 0, status = MEMORY_ACCESS_OK.
  - in-flight requests are dropped with no array write; array contents are not reset.
- Always ready, no backpressure: a request is accepted on every posedge where req[p] = 1.
- Latency: a request sampled at edge E0 gives rsp_valid[p] = 1 for exactly one cycle after edge E(latency-1).
  - latency 1: array access and response register both at E0.
  - latency 2: input register at E0, access and response at E1.
  - latency 3: input register at E0, access at E1, output register at E2.
- Back-to-back requests on every cycle give back-to-back responses, in order per port.
- Error checks (evaluated on the sampled request, in priority order):
  - address > word_count*word_size-1 gives MEMORY_ERROR_OUT_OF_BOUNDS.
  - otherwise, address[$clog2(word_size)-1:0] != 0 gives MEMORY_ERROR_MISALIGNED.
  - otherwise MEMORY_ACCESS_OK.
  - an errored request performs no read and no write, and returns rdata = 0.
- Word index = address[addr_width-2:$clog2(word_size)].
- Writes: at the access edge, only bytes with wmask set are updated.
  - a write with wmask = 0 is a legal no-op and returns status OK.
  - write responses carry rdata = 0.
- Read-during-write is read-first: a read whose access edge equals a write's access edge, on the same word, returns the old data. Reads with a later access edge see the new data.
- Write-write collision (same word, same access edge, overlapping mask bits): per byte, the lowest-numbered port wins. Non-overlapping bytes from all ports are merged.
- Ports with req = 0 never generate responses. rdata and status hold their last values while rsp_valid = 0.
- Reset asserted mid-pipeline: no response is produced for any request sampled before reset release.

Decomposition:
- Shared package memory_pkg:
  - memory_status_t, declared as logic [2:0] with the values MEMORY_ACCESS_OK, MEMORY_WAIT_READY, MEMORY_ERROR_OUT_OF_BOUNDS, MEMORY_ERROR_MISALIGNED, MEMORY_ERROR_READONLY, MEMORY_ERROR_WRITEONLY, in that order.
  - a function for the alignment and bounds check, shared with writeback_cache.
- One sub-module, ram_port_pipe, instantiated once per port. It holds the input and output pipeline registers, the valid bits and the error decode.
- The array and the collision merge stay in multi_port_ram.

Test Plan:
- Reset then idle: after reset release, rsp_valid = 0, rdata = 0, status = OK for 10 cycles.
- Basic write/read, latency 2, port 0: write 0x0000_0010 = 0xDEADBEEF, mask 4'hF; read 0x10 on the next cycle. The read response arrives 2 cycles after its request with rdata = 0xDEADBEEF and status OK. Repeat the sequence for latency 1 and latency 3 and check the timing.
- Byte mask and collision: word 0x20 holds 0x11223344. In the same cycle, port 0 writes 0xAAAAAAAA with mask 4'b0011 and port 1 writes 0xBBBBBBBB with mask 4'b0110. A subsequent read returns 0x11BBAAAA (port 0 wins byte 1).
- Read-first: word 0x40 holds 0x0. In the same cycle, port 0 reads 0x40 and port 1 writes 0x12345678. Port 0 returns 0x0; a read of 0x40 one cycle later returns 0x12345678.
- Errors (word_count 256, word_size 4):
  - read of 0x402 gives OUT_OF_BOUNDS, rdata 0.
  - write of 0x0006 gives MISALIGNED, and a later read of 0x4 is unchanged.
- Reset mid-flight, latency 3: issue reads on cycles 0-2 and assert reset on cycle 3. No rsp_valid appears after release; a write issued 1 cycle before reset is not committed.
